windowed_register_file: RTL

//  - SPARC windowed integer register file: 8 globals plus NWINDOWS x 16 windowed registers.
//  - Provides NUM_RD registered read ports and one write port.
//  - Holds the current window pointer (CWP); handles SAVE/RESTORE and window overflow/underflow detection.
//  - Sits in the data path between decode (register selects) and the ALU operand latches.

---
 rtl/windowed_register_file.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/windowed_register_file.sv
// SPARC-style windowed integer register file: 8 globals, NWINDOWS x 16 windowed registers,
// NUM_RD registered read ports, one write port, CWP with SAVE/RESTORE trap detection.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module windowed_register_file #(
  parameter  int DATA_W   = 32,
  parameter  int NWINDOWS = 8,
  parameter  int NUM_RD   = 2,
  localparam int CWP_W    = $clog2(NWINDOWS)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*5-1:0]      Rd_Sel,
  output logic [NUM_RD*DATA_W-1:0] Rd_Data,
  input  logic                     Wr_En,
  input  logic [4:0]               Wr_Sel,
  input  logic [DATA_W-1:0]        Wr_Data,
  input  logic                     Save,
  input  logic                     Restore,
  input  logic [NWINDOWS-1:0]      Wim,
  input  logic                     Cwp_Load,
  input  logic [CWP_W-1:0]         Cwp_Load_Val,
  output logic [CWP_W-1:0]         Cwp,
  output logic                     Window_Overflow,
  output logic                     Window_Underflow
);

  localparam int NPHYS  = 16 * NWINDOWS;
  localparam int PHYS_W = CWP_W + 4;

  // Window w starts at w*16; the modulo wrap makes window N-1's ins land on window 0's outs.
  function automatic logic [PHYS_W-1:0] f_phys(input logic [CWP_W-1:0] cwp, input logic [4:0] sel);
    logic [PHYS_W:0] sum;
    sum = {1'b0, cwp, 4'b0000} + {{CWP_W{1'b0}}, sel - 5'd8};
    return sum[PHYS_W-1:0];
  endfunction

  // NOTE: storage arrays carry no reset so they map onto plain RAM/flop arrays; r0 is forced to 0 on read.
  logic [DATA_W-1:0] r_glob [8];
  logic [DATA_W-1:0] r_win  [NPHYS];
  logic [DATA_W-1:0] r_rd   [NUM_RD];
  logic [CWP_W-1:0]  r_cwp;
  logic              r_ovf;
  logic              r_unf;

  logic              w_wr_act;
  logic [PHYS_W-1:0] w_wr_phys;
  logic [4:0]        w_rd_sel  [NUM_RD];
  logic [DATA_W-1:0] w_rd_next [NUM_RD];
  logic [CWP_W-1:0]  w_cwp_next;
  logic [CWP_W-1:0]  w_cwp_dn;
  logic [CWP_W-1:0]  w_cwp_up;
  logic              w_ovf_next;
  logic              w_unf_next;

  assign w_wr_act  = Wr_En && (Wr_Sel != 5'd0);
  assign w_wr_phys = f_phys(r_cwp, Wr_Sel);

  // Reads and writes both use the CWP held before the edge, so a SAVE/RESTORE cycle still sees the old window.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_sel[k]  = Rd_Sel[5*k +: 5];
      w_rd_next[k] = '0;
      if (w_rd_sel[k] == 5'd0)
        w_rd_next[k] = '0;
      else if (w_rd_sel[k] < 5'd8)
        w_rd_next[k] = r_glob[w_rd_sel[k][2:0]];
      else
        w_rd_next[k] = r_win[f_phys(r_cwp, w_rd_sel[k])];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_act && (w_rd_sel[k] != 5'd0)) begin
        if (w_rd_sel[k] < 5'd8) begin
          if (w_rd_sel[k] == Wr_Sel)
            w_rd_next[k] = Wr_Data;
        end else if ((Wr_Sel >= 5'd8) && (f_phys(r_cwp, w_rd_sel[k]) == w_wr_phys)) begin
          w_rd_next[k] = Wr_Data;
        end
      end
`endif
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset && w_wr_act) begin
      if (Wr_Sel < 5'd8)
        r_glob[Wr_Sel[2:0]] <= Wr_Data;
      else
        r_win[w_wr_phys] <= Wr_Data;
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < NUM_RD; k++) begin
      if (Reset)
        r_rd[k] <= '0;
      else
        r_rd[k] <= w_rd_next[k];
    end
  end

  assign w_cwp_dn = r_cwp - 1'b1;
  assign w_cwp_up = r_cwp + 1'b1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cwp_next = r_cwp;
    w_ovf_next = 1'b0;
    w_unf_next = 1'b0;
    if (Cwp_Load) begin
      w_cwp_next = Cwp_Load_Val;
    end else if (Save && !Restore) begin
      if (Wim[w_cwp_dn]) w_ovf_next = 1'b1;
      else               w_cwp_next = w_cwp_dn;
    end else if (Restore && !Save) begin
      if (Wim[w_cwp_up]) w_unf_next = 1'b1;
      else               w_cwp_next = w_cwp_up;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cwp <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cwp <= w_cwp_next;
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_out
    assign Rd_Data[DATA_W*k +: DATA_W] = r_rd[k];
  end

  assign Cwp              = r_cwp;
  assign Window_Overflow  = r_ovf;
  assign Window_Underflow = r_unf;

endmodule
